// File: rtl/tc_mma_pkg.sv
// Shared definitions for the tensor-core tile issuer: default tile shape,
// controller states and the FP16/FP32 element types.
package tc_mma_pkg;

   localparam int M_DEF = 4;
   localparam int N_DEF = 4;
   localparam int K_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRAIN,
      ISSUE,
      WAIT,
      STORE,
      DONE
   } state_t;

   typedef logic [15:0] fp16_t;
   typedef logic [31:0] fp32_t;

endpackage

// File: rtl/tc_tile_buffer.sv
// Staging storage for one tile job: word-indexed load of packed A/B and C words,
// FP16 unpacking onto the matrix buses, and a full-width capture of the D result.
import tc_mma_pkg::*;

module tc_tile_buffer #(
   parameter int M = M_DEF,
   parameter int N = N_DEF,
   parameter int K = K_DEF,
   localparam int NA = M * K / 2,
   localparam int NB = K * N / 2,
   localparam int NC = M * N,
   localparam int NW = NA + NB + NC,
   localparam int IW = $clog2(NW),
   localparam int DW = $clog2(NC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_idx,
   input  fp32_t             wr_data,
   input  logic              d_capture,
   input  logic [32*NC-1:0]  matrix_d,
   input  logic [DW-1:0]     d_idx,
   output fp32_t             d_word,
   output logic [16*M*K-1:0] matrix_a,
   output logic [16*K*N-1:0] matrix_b,
   output logic [32*NC-1:0]  matrix_c
);

   // Word layout: A words, then B words, then C words, in load order.
   fp32_t words [NW];
   fp32_t d_words [NC];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) words[i] <= '0;
         for (int i = 0; i < NC; i++) d_words[i] <= '0;
      end else begin
         if (wr_en) words[wr_idx] <= wr_data;
         if (d_capture) begin
            for (int i = 0; i < NC; i++) d_words[i] <= matrix_d[32*i +: 32];
         end
      end
   end

   assign d_word = d_words[d_idx];

   // Even elements sit in the low half of each word, odd ones in the high half.
   for (genvar gi = 0; gi < M * K; gi++) begin : g_a
      assign matrix_a[16*gi +: 16] = words[gi/2][16*(gi%2) +: 16];
   end

   for (genvar gi = 0; gi < K * N; gi++) begin : g_b
      assign matrix_b[16*gi +: 16] = words[NA + gi/2][16*(gi%2) +: 16];
   end

   for (genvar gi = 0; gi < NC; gi++) begin : g_c
      assign matrix_c[32*gi +: 32] = words[NA + NB + gi];
   end

endmodule

// File: rtl/tc_mma_issuer.sv
// Tile job controller: loads A/B/C from word memory, hands the tile to the
// tensor core, captures D and streams it back to memory.
import tc_mma_pkg::*;

module tc_mma_issuer #(
   parameter int M  = M_DEF,
   parameter int N  = N_DEF,
   parameter int K  = K_DEF,
   parameter int AW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [AW-1:0]     cmd_a_addr,
   input  logic [AW-1:0]     cmd_b_addr,
   input  logic [AW-1:0]     cmd_c_addr,
   input  logic [AW-1:0]     cmd_d_addr,
   output logic              done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              mma_enable,
   output logic              mma_valid,
   input  logic              mma_ready,
   input  logic              result_valid,
   output logic [16*M*K-1:0] matrix_a,
   output logic [16*K*N-1:0] matrix_b,
   output logic [32*M*N-1:0] matrix_c,
   input  logic [32*M*N-1:0] matrix_d
);

   localparam int NA = M * K / 2;
   localparam int NB = K * N / 2;
   localparam int NC = M * N;
   localparam int NW = NA + NB + NC;
   localparam int IW = $clog2(NW);
   localparam int DW = $clog2(NC);
   localparam int CW = $clog2(NW + 1);

   if ((M * K) % 2 != 0 || (K * N) % 2 != 0) begin : g_odd_tile
      $error("tc_mma_issuer: M*K and K*N must be even for FP16 word packing");
   end

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [AW-1:0]   a_base_reg, b_base_reg, c_base_reg, d_base_reg;
   logic            pend_reg;
   logic [IW-1:0]   pend_idx_reg;
   logic            d_capture;
   fp32_t           d_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         a_base_reg   <= '0;
         b_base_reg   <= '0;
         c_base_reg   <= '0;
         d_base_reg   <= '0;
         pend_reg     <= 1'b0;
         pend_idx_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (cmd_valid && cmd_ready) begin
            a_base_reg <= cmd_a_addr;
            b_base_reg <= cmd_b_addr;
            c_base_reg <= cmd_c_addr;
            d_base_reg <= cmd_d_addr;
         end
         // Read data returns one cycle later; remember which slot it belongs to.
         pend_reg     <= (state_reg == LOAD);
         pend_idx_reg <= cnt_reg[IW-1:0];
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cmd_ready  = 1'b0;
      done       = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mma_enable = 1'b1;
      mma_valid  = 1'b0;
      d_capture  = 1'b0;
      case (state_reg)
         IDLE: begin
            mma_enable = 1'b0;
            cmd_ready  = 1'b1;
            cnt_next   = '0;
            if (cmd_valid) state_next = LOAD;
         end
         LOAD: begin
            mem_req = 1'b1;
            if (cnt_reg < CW'(NA))
               mem_addr = a_base_reg + AW'(cnt_reg);
            else if (cnt_reg < CW'(NA + NB))
               mem_addr = b_base_reg + AW'(cnt_reg - CW'(NA));
            else
               mem_addr = c_base_reg + AW'(cnt_reg - CW'(NA + NB));
            if (cnt_reg == CW'(NW - 1)) begin
               cnt_next   = '0;
               state_next = DRAIN;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DRAIN: state_next = ISSUE;
         ISSUE: begin
            mma_valid = 1'b1;
            if (mma_ready) state_next = WAIT;
         end
         WAIT: begin
            if (result_valid) begin
               d_capture  = 1'b1;
               state_next = STORE;
            end
         end
         STORE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = d_base_reg + AW'(cnt_reg);
            mem_wdata = d_word;
            if (cnt_reg == CW'(NC - 1)) begin
               cnt_next   = '0;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   tc_tile_buffer #(
      .M(M),
      .N(N),
      .K(K)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (pend_reg),
      .wr_idx    (pend_idx_reg),
      .wr_data   (mem_rdata),
      .d_capture (d_capture),
      .matrix_d  (matrix_d),
      .d_idx     (cnt_reg[DW-1:0]),
      .d_word    (d_word),
      .matrix_a  (matrix_a),
      .matrix_b  (matrix_b),
      .matrix_c  (matrix_c)
   );

endmodule

// File: doc/tc_mma_issuer.md
TC_MMA_ISSUER -- requirements
Module: tc_mma_issuer

Interface
REQ-001 Parameters SHALL be: M, default 4, tile rows; N, default 4, tile columns; K, default 4, reduction depth; AW, default 16, memory word-address width.
REQ-002 Ports SHALL be:
  clk  in  1  sole clock, rising edge;
  rst  in  1  asynchronous, active-high reset;
  cmd_valid  in  1  command offered;
  cmd_ready  out  1  command accepted when both high;
  cmd_a_addr / cmd_b_addr / cmd_c_addr / cmd_d_addr  in  AW each  word base addresses;
  done  out  1  one-cycle completion pulse;
  mem_req  out  1  memory access this cycle;
  mem_we  out  1  1 = write, 0 = read;
  mem_addr  out  AW  word address;
  mem_wdata  out  32  write data;
  mem_rdata  in  32  read data, valid exactly 1 cycle after a read request;
  mma_enable  out  1  tensor-core enable;
  mma_valid  out  1  tile issue request;
  mma_ready  in  1  core can accept;
  result_valid  in  1  matrix_d valid;
  matrix_a  out  16 x M*K  FP16, row-major;
  matrix_b  out  16 x K*N  FP16, row-major;
  matrix_c  out  32 x M*N  FP32, row-major;
  matrix_d  in  32 x M*N  FP32, row-major.

Function
REQ-003 States SHALL be IDLE, LOAD, DRAIN, ISSUE, WAIT, STORE, DONE.
REQ-004 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE is ignored.
REQ-005 On cmd_valid & cmd_ready the block SHALL latch all four addresses and enter LOAD.
REQ-006 LOAD SHALL issue one read per cycle, no gaps, in order: A words, then B words, then C words. Counts: M*K/2 A words, K*N/2 B words, M*N C words. Addresses: base+i.
REQ-007 FP16 packing: word i SHALL hold element 2i in bits [15:0] and element 2i+1 in [31:16]. M*K and K*N SHALL be even (elaboration assertion).
REQ-008 Each returning mem_rdata SHALL be written into the staging buffer slot of the request issued the previous cycle.
REQ-009 After the last read, the block SHALL spend exactly one DRAIN cycle capturing the final word, then enter ISSUE.
REQ-010 Default-config timing: accept at cycle T; reads at T+1..T+32; DRAIN at T+33; ISSUE from T+34.
REQ-011 In ISSUE, mma_valid SHALL be 1. Transfer occurs when mma_valid & mma_ready; state then goes to WAIT. mma_valid SHALL be 0 in every other state.
REQ-012 matrix_a/b/c SHALL be driven from the staging buffer and held stable from DRAIN through the end of WAIT.
REQ-013 mma_enable SHALL be 1 in every state except IDLE.
REQ-014 In WAIT, the first cycle with result_valid=1 SHALL capture matrix_d into the buffer and move to STORE.
REQ-015 result_valid in any state other than WAIT SHALL be ignored. result_valid held high for several cycles SHALL cause exactly one capture.
REQ-016 STORE SHALL issue M*N consecutive writes (mem_req=1, mem_we=1, mem_addr=d_base+i, mem_wdata=D[i]), one per cycle, then enter DONE.
REQ-017 DONE SHALL assert done for one cycle and return to IDLE. A new command is accepted no earlier than the cycle after done.
REQ-018 mem_req SHALL be 0 in IDLE, DRAIN, ISSUE, WAIT and DONE. mem_we SHALL be 0 whenever mem_req=0.
REQ-019 Address arithmetic SHALL wrap modulo 2^AW.

Reset
REQ-020 While rst=1, state SHALL be IDLE and every output 0, except cmd_ready=1.
REQ-021 Reset asserted mid-operation SHALL abandon the command immediately: no further mem writes, no done pulse, staging buffer cleared to 0.

Structure
REQ-022 A shared package tc_mma_pkg SHALL hold the M/N/K defaults, the state enum, and the fp16_t/fp32_t typedefs.
REQ-023 The staging storage SHALL be one sub-module, tc_tile_buffer: word-indexed write, FP16 unpacking, and D capture.

Verification
REQ-024 A=2.0 on diagonal, 1.0 elsewhere; B all 1.0; C zero except C(0,0)=3.0, C(2,0)=2.0, C(2,2)=5.0; reference core model -> writes to d_base+0=0x41000000 (8.0), d_base+8=0x40E00000 (7.0), d_base+10=0x41200000 (10.0), all other words 0x40A00000 (5.0); done exactly once.
REQ-025 mma_ready held low for 5 cycles after entering ISSUE -> mma_valid held high all 5 cycles; matrix_a unchanged; single transfer.
REQ-026 result_valid held high for 3 cycles -> exactly 16 writes, one done.
REQ-027 rst pulsed during LOAD at cycle T+10 -> all outputs 0 next cycle; cmd_ready=1 after release; no writes observed.
REQ-028 cmd_valid asserted during WAIT with different addresses -> ignored; the original d_base is used for STORE.
REQ-029 cmd_d_addr=0xFFFE -> writes to 0xFFFE, 0xFFFF, 0x0000..0x000D.
